// File: rtl/pipelined_adder_sub.sv
// Chunked, pipelined two's-complement adder/subtractor with NZCV flags.
// Each stage ripples one CW-bit chunk and hands its carry to the next stage.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Global stall: every stage moves together or holds together.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~B : B;

  for (genvar j = 0; j < STAGES; j++) begin : g_stage
    localparam int unsigned RW = (j + 1) * CW;

    logic [CW-1:0] a_c;
    logic [CW-1:0] b_c;
    logic          cin;
    logic          zin;
    logic          vin;
    logic [CW:0]   sum;
    logic [RW-1:0] res_nxt;

    logic          v_q;
    logic          c_q;
    logic          z_q;
    logic [RW-1:0] res_q;

    if (j == 0) begin : g_first
      assign a_c     = A[CW-1:0];
      assign b_c     = b_eff[CW-1:0];
      assign cin     = sub;
      assign zin     = 1'b1;
      assign vin     = in_valid;
      assign res_nxt = sum[CW-1:0];
    end else begin : g_next
      assign a_c     = g_stage[j-1].g_pend.pa_q[CW-1:0];
      assign b_c     = g_stage[j-1].g_pend.pb_q[CW-1:0];
      assign cin     = g_stage[j-1].c_q;
      assign zin     = g_stage[j-1].z_q;
      assign vin     = g_stage[j-1].v_q;
      assign res_nxt = {sum[CW-1:0], g_stage[j-1].res_q};
    end

    assign sum = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, cin};

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= vin;
        c_q   <= sum[CW];
        z_q   <= zin & (sum[CW-1:0] == '0);
        res_q <= res_nxt;
      end
    end

    // High operand chunks still waiting for their stage.
    if (j < STAGES - 1) begin : g_pend
      localparam int unsigned PW = WIDTH - (j + 1) * CW;

      logic [PW-1:0] pa_nxt;
      logic [PW-1:0] pb_nxt;
      logic [PW-1:0] pa_q;
      logic [PW-1:0] pb_q;

      if (j == 0) begin : g_src_in
        assign pa_nxt = A[WIDTH-1:CW];
        assign pb_nxt = b_eff[WIDTH-1:CW];
      end else begin : g_src_prev
        assign pa_nxt = g_stage[j-1].g_pend.pa_q[WIDTH-j*CW-1:CW];
        assign pb_nxt = g_stage[j-1].g_pend.pb_q[WIDTH-j*CW-1:CW];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          pa_q <= '0;
          pb_q <= '0;
        end else if (adv) begin
          pa_q <= pa_nxt;
          pb_q <= pb_nxt;
        end
      end
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    if (j == STAGES - 1) begin : g_last
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= a_c[CW-1] ^ b_c[CW-1] ^ sum[CW-1] ^ sum[CW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign result    = g_stage[STAGES-1].res_q;
  assign negative  = g_stage[STAGES-1].res_q[WIDTH-1];
  assign zero      = g_stage[STAGES-1].z_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule
